// File: rtl/opt_cmd_gen.sv
// opt_cmd_gen: per-replica local-search move command generator.
// Draws candidate city indices from a 32-bit Galois LFSR, filters them into
// legal 2-opt / or-opt (K, L) pairs and hands out one command per replica,
// round-robin, over a valid/ready handshake.
// Optional feature macro: REPLICA_OR_OPT_EN (or-opt moves and cmd_mode).
// Without it every command is a 2-opt move (TWO, K < L).
module opt_cmd_gen #(
  parameter int unsigned CITY_NUM    = 30,
  parameter int unsigned IDX_W       = $clog2(CITY_NUM),
  parameter int unsigned REPLICA_NUM = 32,
  parameter int unsigned REP_W       = $clog2(REPLICA_NUM),
  parameter logic [31:0] SEED        = 32'h1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_we,
  input  logic [31:0]      seed,
  input  logic [1:0]       cmd_mode,
  output logic             opt_valid,
  input  logic             opt_ready,
  output logic [1:0]       opt_cmd,
  output logic [IDX_W-1:0] opt_k,
  output logic [IDX_W-1:0] opt_l,
  output logic [REP_W-1:0] replica_id
);

  localparam logic [1:0]       CmdThr    = 2'b00;
  localparam logic [1:0]       CmdTwo    = 2'b01;
`ifdef REPLICA_OR_OPT_EN
  localparam logic [1:0]       CmdOr0    = 2'b10;
  localparam logic [1:0]       CmdOr1    = 2'b11;
  localparam logic [IDX_W:0]   IdxOneW   = (IDX_W + 1)'(1);
`endif
  localparam logic [31:0]      LfsrTaps  = 32'h8020_0003;
  localparam logic [IDX_W-1:0] IdxMax    = IDX_W'(CITY_NUM - 1);
  localparam logic [REP_W-1:0] RepLast   = REP_W'(REPLICA_NUM - 1);

  typedef enum logic [1:0] {StIdle, StDrawK, StDrawL, StOut} state_e;

  state_e           r_state;
  logic [31:0]      r_lfsr;
  logic [IDX_W-1:0] r_a;      // first accepted index of the move being drawn
  logic [REP_W-1:0] r_rid;
  logic             r_valid;
  logic [1:0]       r_cmd;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] r_l;

  logic [31:0]      w_lfsr_step;
  logic [31:0]      w_seed_val;
  logic [IDX_W-1:0] w_cand;
  logic             w_cand_ok;
  logic             w_use_or;
  logic             w_l_accept;
  logic [1:0]       w_l_cmd;
  logic [IDX_W-1:0] w_l_k;
  logic [IDX_W-1:0] w_l_l;

  // Galois step; the candidate is taken from the post-step value.
  assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LfsrTaps : 32'h0);
  assign w_seed_val  = (seed == 32'h0) ? SEED : seed;
  assign w_cand      = w_lfsr_step[IDX_W-1:0];
  assign w_cand_ok   = (w_cand != '0) && (w_cand <= IdxMax);

`ifdef REPLICA_OR_OPT_EN
  logic w_a_gt_c1;
  assign w_a_gt_c1 = {1'b0, r_a} > ({1'b0, w_cand} + IdxOneW);

  // Move type for the current DRAW_L evaluation; mixed mode uses LFSR bit 31.
  always_comb begin
    w_use_or = 1'b0;
    case (cmd_mode)
      2'b01:   w_use_or = 1'b1;
      2'b10:   w_use_or = w_lfsr_step[31];
      default: w_use_or = 1'b0;
    endcase
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = ^cmd_mode;
  assign w_use_or      = 1'b0;
`endif

  // Accept/reject the L candidate and order K/L for the selected move type.
  always_comb begin
    w_l_accept = 1'b0;
    w_l_cmd    = CmdTwo;
    w_l_k      = r_a;
    w_l_l      = w_cand;
    if (w_cand_ok && (w_cand != r_a)) begin
      if (!w_use_or) begin
        w_l_accept = 1'b1;
        w_l_cmd    = CmdTwo;
        if (w_cand < r_a) begin
          w_l_k = w_cand;
          w_l_l = r_a;
        end
      end
`ifdef REPLICA_OR_OPT_EN
      else if (w_cand > r_a) begin
        w_l_accept = 1'b1;
        w_l_cmd    = CmdOr0;
      end else if (w_a_gt_c1) begin
        // c == a-1 falls through here and is rejected
        w_l_accept = 1'b1;
        w_l_cmd    = CmdOr1;
      end
`endif
    end
  end

  // Control FSM, LFSR and registered command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_lfsr  <= SEED;
      r_a     <= '0;
      r_rid   <= '0;
      r_valid <= 1'b0;
      r_cmd   <= CmdThr;
      r_k     <= '0;
      r_l     <= '0;
    end else begin
      // A seed load replaces the step and suppresses that cycle's draw.
      if (seed_we) begin
        r_lfsr <= w_seed_val;
      end else if ((r_state == StDrawK) || (r_state == StDrawL)) begin
        r_lfsr <= w_lfsr_step;
      end

      unique case (r_state)
        StIdle: begin
          if (enable) r_state <= StDrawK;
        end
        StDrawK: begin
          if (!seed_we && w_cand_ok) begin
            r_a     <= w_cand;
            r_state <= StDrawL;
          end
        end
        StDrawL: begin
          if (!seed_we && w_l_accept) begin
            r_cmd   <= w_l_cmd;
            r_k     <= w_l_k;
            r_l     <= w_l_l;
            r_valid <= 1'b1;
            r_state <= StOut;
          end
        end
        StOut: begin
          if (opt_ready) begin
            r_valid <= 1'b0;
            r_rid   <= (r_rid == RepLast) ? '0 : r_rid + REP_W'(1);
            r_state <= enable ? StDrawK : StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign opt_valid  = r_valid;
  assign opt_cmd    = r_cmd;
  assign opt_k      = r_k;
  assign opt_l      = r_l;
  assign replica_id = r_rid;

endmodule
